// File: rtl/apb_pkg.sv
// Shared types and helpers for the parametrised APB memory slave.
package apb_pkg;

    typedef enum logic {IDLE, ACCESS} apb_slv_state_e;

    localparam int WAIT_CNT_W = 4;

    // Byte address -> word index for the given data width.
    function automatic logic [63:0] word_index(input logic [63:0] paddr, input int data_w);
        case (data_w)
            16:      return paddr >> 1;
            32:      return paddr >> 2;
            64:      return paddr >> 3;
            default: return paddr;
        endcase
    endfunction

endpackage

// File: rtl/apb_byte_ram.sv
// DEPTH x DATA_W storage split into byte lanes; async read, per-lane write enable,
// reset loads each word with its own index.
module apb_byte_ram #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 8
) (
    input  logic                pclk,
    input  logic                rst,
    input  logic                we,
    input  logic [IDX_W-1:0]    waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic [IDX_W-1:0]    raddr,
    output logic [DATA_W-1:0]   rdata
);
    localparam int NB = DATA_W / 8;

    for (genvar b = 0; b < NB; b++) begin : g_lane
        logic [7:0] mem [DEPTH];

        always_ff @(posedge pclk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++)
                    mem[i] <= 8'(i >> (8 * b));
            end else if (we && wstrb[b]) begin
                mem[waddr] <= wdata[8*b +: 8];
            end
        end

        assign rdata[8*b +: 8] = mem[raddr];
    end

endmodule

// File: rtl/apb_mem_slave.sv
// APB4 memory slave: setup-phase decode, programmable wait states, byte strobes,
// PSLVERR on out-of-range or misaligned addresses.
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                pclk,
    input  logic                rst,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    output logic                pready,
    output logic [DATA_W-1:0]   prdata,
    output logic                pslverr
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]       DEPTH_A   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0]     OFF_MASK  = ADDR_W'((1 << OFF_W) - 1);
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);

    if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32 || DATA_W == 64)) begin : g_chk_dw
        $error("apb_mem_slave: DATA_W must be 8, 16, 32 or 64");
    end
    if (DEPTH < 1) begin : g_chk_depth
        $error("apb_mem_slave: DEPTH must be at least 1");
    end
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_chk_wait
        $error("apb_mem_slave: WAIT_CYCLES must be 0..15");
    end
    if (ADDR_W > 64 || ADDR_W < OFF_W + $clog2(DEPTH)) begin : g_chk_addr
        $error("apb_mem_slave: ADDR_W cannot address DEPTH words");
    end

    apb_slv_state_e        state;
    logic [WAIT_CNT_W-1:0] cnt;
    logic [IDX_W-1:0]      idx_q;
    logic                  wr_q;
    logic                  err_q;
    logic [DATA_W-1:0]     rdata_q;

    logic [ADDR_W-1:0] full_idx;
    logic              addr_err;
    logic [IDX_W-1:0]  ram_raddr;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] setup_rd;
    logic              ram_we;

    assign full_idx  = ADDR_W'(word_index(64'(paddr), DATA_W));
    assign addr_err  = ({1'b0, full_idx} >= DEPTH_A) || ((paddr & OFF_MASK) != '0);
    assign ram_raddr = IDX_W'(full_idx);
    assign setup_rd  = (pwrite || addr_err) ? '0 : ram_rdata;
    // pready is high exactly in the completing access cycle, so this is the commit edge.
    assign ram_we    = pready && psel && penable && wr_q && !err_q;

    apb_byte_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_ram (
        .pclk  (pclk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (idx_q),
        .wdata (pwdata),
        .wstrb (pstrb),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (psel && !penable) begin
                        state   <= ACCESS;
                        idx_q   <= ram_raddr;
                        wr_q    <= pwrite;
                        err_q   <= addr_err;
                        cnt     <= WAIT_INIT;
                        rdata_q <= setup_rd;
                        pready  <= (WAIT_CYCLES == 0);
                        pslverr <= (WAIT_CYCLES == 0) && addr_err;
                        prdata  <= (WAIT_CYCLES == 0) ? setup_rd : '0;
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        state   <= IDLE;
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                        prdata  <= '0;
                    end else if (penable) begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                            if (cnt == WAIT_CNT_W'(1)) begin
                                pready  <= 1'b1;
                                pslverr <= err_q;
                                prdata  <= rdata_q;
                            end
                        end else begin
                            state   <= IDLE;
                            pready  <= 1'b0;
                            pslverr <= 1'b0;
                            prdata  <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
